// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The master side (requester) drives start/a/b; the slave side (the
// subtractor) drives busy/done/diff/borrow.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN adds the signed overflow flag ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf;

  modport master (output start, output a, output b,
                  input busy, input done, input diff, input borrow, input ovf);
  modport slave  (input start, input a, input b,
                  output busy, output done, output diff, output borrow, output ovf);
`else
  modport master (output start, output a, output b,
                  input busy, input done, input diff, input borrow);
  modport slave  (input start, input a, input b,
                  output busy, output done, output diff, output borrow);
`endif

endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH) plus final borrow.
// One full-subtractor cell and a borrow flip-flop consume one operand bit
// per clock, LSB first. FSM: IDLE -> SHIFT (WIDTH edges) -> DONE.
//
// The outputs form a register stage one clock behind the FSM state: busy is
// visible during the WIDTH cycles after each SHIFT edge, and done/diff/borrow
// are loaded on the edge that leaves DONE. With start sampled at edge N this
// puts the done pulse in the cycle after edge N+WIDTH+1, and a start seen in
// DONE is taken on that same edge, so results arrive every WIDTH+1 clocks.
//
// Optional macro SERIAL_SUB_SIGNED_OVF_EN: adds output ovf, the two's-
// complement overflow of the subtraction, derived from the captured operand
// MSBs (not the live inputs).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Full-subtractor difference bit.
  function automatic logic sub_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  // Full-subtractor borrow out.
  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic [CW-1:0]    cnt_r;
  logic             borrow_ff_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             d_s;
  logic             bnext_s;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
  logic             ovf_r;
`endif

  // Single subtractor cell working on the current LSBs.
  always_comb begin
    d_s     = sub_diff(a_sr_r[0], b_sr_r[0], borrow_ff_r);
    bnext_s = sub_borrow(a_sr_r[0], b_sr_r[0], borrow_ff_r);
  end

  // FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      a_sr_r      <= {WIDTH{1'b0}};
      b_sr_r      <= {WIDTH{1'b0}};
      res_sr_r    <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      borrow_ff_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      diff_r      <= {WIDTH{1'b0}};
      borrow_r    <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_r     <= 1'b0;
      b_msb_r     <= 1'b0;
      ovf_r       <= 1'b0;
`endif
    end else begin
      busy_r <= (state_r == S_SHIFT);
      done_r <= (state_r == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            a_sr_r      <= bus.a;
            b_sr_r      <= bus.b;
            res_sr_r    <= {WIDTH{1'b0}};
            borrow_ff_r <= 1'b0;
            cnt_r       <= {CW{1'b0}};
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_r     <= bus.a[WIDTH-1];
            b_msb_r     <= bus.b[WIDTH-1];
`endif
            state_r     <= S_SHIFT;
          end else begin
            state_r     <= S_IDLE;
          end
        end
        S_SHIFT: begin
          res_sr_r    <= {d_s, res_sr_r[WIDTH-1:1]};
          a_sr_r      <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r      <= {1'b0, b_sr_r[WIDTH-1:1]};
          borrow_ff_r <= bnext_s;
          cnt_r       <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            state_r <= S_DONE;
          end else begin
            state_r <= S_SHIFT;
          end
        end
        S_DONE: begin
          // Result is complete in res_sr_r/borrow_ff_r; publish it.
          diff_r   <= res_sr_r;
          borrow_r <= borrow_ff_r;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          ovf_r    <= (a_msb_r != b_msb_r) && (res_sr_r[WIDTH-1] != a_msb_r);
`endif
          if (bus.start) begin
            a_sr_r      <= bus.a;
            b_sr_r      <= bus.b;
            res_sr_r    <= {WIDTH{1'b0}};
            borrow_ff_r <= 1'b0;
            cnt_r       <= {CW{1'b0}};
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_r     <= bus.a[WIDTH-1];
            b_msb_r     <= bus.b[WIDTH-1];
`endif
            state_r     <= S_SHIFT;
          end else begin
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.diff   = diff_r;
  assign bus.borrow = borrow_r;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign bus.ovf    = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): a transaction-level
// reference (result = a - b, timed by edge counts since acceptance) is
// compared with the DUT every cycle, plus directed literal expectations.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN also checks ovf.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc;
  int         acc_cyc;
  int         age;
  logic       in_flight;
  logic [7:0] pend_diff;
  logic       pend_borrow;
  logic       pend_ovf;
  logic       exp_busy;
  logic       exp_done;
  logic [7:0] exp_diff;
  logic       exp_borrow;
  logic       exp_ovf;

  // Operation timing: accepted at edge N, busy after N+1..N+WIDTH, result
  // and done after edge N+WIDTH+1, where a new start may be accepted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; acc_cyc = 0; in_flight = 1'b0;
      exp_busy = 1'b0; exp_done = 1'b0;
      exp_diff = 8'h00; exp_borrow = 1'b0; exp_ovf = 1'b0;
    end else begin
      cyc++;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (in_flight) begin
        age = cyc - acc_cyc;
        if (age <= WIDTH) exp_busy = 1'b1;
        if (age == WIDTH + 1) begin
          exp_done   = 1'b1;
          exp_diff   = pend_diff;
          exp_borrow = pend_borrow;
          exp_ovf    = pend_ovf;
          in_flight  = 1'b0;
        end
      end
      if (!in_flight && bus.start === 1'b1) begin
        in_flight   = 1'b1;
        acc_cyc     = cyc;
        pend_diff   = 8'(bus.a - bus.b);
        pend_borrow = (bus.a < bus.b);
        pend_ovf    = (bus.a[7] != bus.b[7]) && (pend_diff[7] != bus.a[7]);
      end
    end
  end

  // Compare DUT outputs to the model shortly after every rising edge.
  always @(posedge clk) begin
    #1;
    check("busy",   64'(bus.busy),   64'(exp_busy));
    check("done",   64'(bus.done),   64'(exp_done));
    check("diff",   64'(bus.diff),   64'(exp_diff));
    check("borrow", 64'(bus.borrow), 64'(exp_borrow));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check("ovf",    64'(bus.ovf),    64'(exp_ovf));
`endif
  end

  // ---------------- directed operation ----------------
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input string nm);
    int k;
    int nbusy;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ia; bus.b = ib;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; nbusy = 0;
    while (bus.done !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
      if (bus.busy === 1'b1) nbusy++;
    end
    check({nm, "_latency"},   64'(k),          64'(9));
    check({nm, "_busycycles"}, 64'(nbusy),     64'(8));
    check({nm, "_diff"},      64'(bus.diff),   64'(ed));
    check({nm, "_borrow"},    64'(bus.borrow), 64'(eb));
    check({nm, "_model_diff"},   64'(exp_diff),   64'(ed));
    check({nm, "_model_borrow"}, 64'(exp_borrow), 64'(eb));
    check({nm, "_model_ovf"},    64'(exp_ovf),    64'(eo));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check({nm, "_ovf"},       64'(bus.ovf),    64'(eo));
`endif
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    tests = 0; fails = 0;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy",   64'(bus.busy),   64'(0));
    check("rst_done",   64'(bus.done),   64'(0));
    check("rst_diff",   64'(bus.diff),   64'(0));
    check("rst_borrow", 64'(bus.borrow), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "op_5m3");
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "op_3m5");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "op_ffmff");
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "op_0mff");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "op_80m1");
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "op_7fmff");
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "op_3m5b");

    // Operands and stray start change mid-SHIFT; diff must hold 0xFE.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    check("midshift_hold_diff", 64'(bus.diff), 64'(8'hFE));
    k = 3;
    while (bus.done !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("midshift_latency", 64'(k),          64'(9));
    check("midshift_diff",    64'(bus.diff),   64'(8'h0F));
    check("midshift_borrow",  64'(bus.borrow), 64'(0));
    repeat (3) @(negedge clk);

    // Back-to-back: start held high, new operands every cycle.
    for (int i = 0; i < 40; i++) begin
      bus.start = 1'b1;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in SHIFT cycle 4: outputs clear at once, no done afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy",   64'(bus.busy),   64'(0));
    check("midrst_done",   64'(bus.done),   64'(0));
    check("midrst_diff",   64'(bus.diff),   64'(0));
    check("midrst_borrow", 64'(bus.borrow), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_nodone_diff", 64'(bus.diff), 64'(0));
    run_op(8'h20, 8'h10, 8'h10, 1'b0, 1'b0, "op_after_rst");

    // Random traffic: sparse starts, some equal operands.
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bus.b = bus.a;
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
